// File: rtl/peak_stream_reader.sv
// peak_stream_reader: captures a 16-entry peak frame and replays it as a valid/ready stream.
// Define PEAK_THRESHOLD_EN to skip entries whose magnitude is below `threshold`.
module peak_stream_reader #(
    parameter int NUM_PEAKS = 16,
    parameter int FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [24:0]        peaks_in [NUM_PEAKS-1:0],
    input  logic               peaks_valid,
    input  logic [15:0]        threshold,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [8:0]         out_bin,
    output logic [15:0]        out_mag,
    output logic [3:0]         out_idx,
    output logic               out_last,
    output logic [FRAME_W-1:0] out_frame,
    output logic               busy,
    output logic               drop,
    output logic               empty_frame
);

    localparam int IDX_W = 4;
    localparam logic [NUM_PEAKS-1:0] ONE = {{(NUM_PEAKS-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 pv_q;
    logic [24:0]          peak_q [NUM_PEAKS-1:0];
    logic [NUM_PEAKS-1:0] pending_q;
    logic [NUM_PEAKS-1:0] pending_d;
    logic [NUM_PEAKS-1:0] mask;
    logic [FRAME_W-1:0]   frame_q;
    logic                 drop_q;
    logic                 cap_evt;
    logic                 capture;
    logic                 fire;
    logic                 last;
    logic [IDX_W-1:0]     idx;

    assign cap_evt = peaks_valid & ~pv_q;
    assign fire    = (state_q == EMIT) & out_ready;

    // Pending mask is sampled in the capture cycle only.
    always_comb begin
        mask = '1;
`ifdef PEAK_THRESHOLD_EN
        for (int i = 0; i < NUM_PEAKS; i++) begin
            mask[i] = (peaks_in[i][15:0] >= threshold);
        end
`endif
    end

    // Lowest set pending bit is the current beat.
    always_comb begin
        idx = '0;
        for (int i = NUM_PEAKS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign last = ((pending_q & (pending_q - ONE)) == '0);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        capture   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cap_evt) begin
                    capture   = 1'b1;
                    pending_d = mask;
                    if (mask != '0) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (fire) begin
                    pending_d[idx] = 1'b0;
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pv_q      <= 1'b0;
            pending_q <= '0;
            frame_q   <= '0;
            drop_q    <= 1'b0;
            for (int i = 0; i < NUM_PEAKS; i++) begin
                peak_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pv_q      <= peaks_valid;
            pending_q <= pending_d;
            // A capture event during EMIT (even on the last beat) is lost.
            drop_q    <= cap_evt & (state_q == EMIT);
            if (capture) begin
                frame_q <= frame_q + FRAME_W'(1);
                for (int i = 0; i < NUM_PEAKS; i++) begin
                    peak_q[i] <= peaks_in[i];
                end
            end
        end
    end

`ifdef PEAK_THRESHOLD_EN
    logic empty_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            empty_q <= 1'b0;
        end else begin
            empty_q <= capture & (mask == '0);
        end
    end

    assign empty_frame = empty_q;
`else
    logic unused_threshold;

    assign unused_threshold = ^threshold;
    assign empty_frame      = 1'b0;
`endif

    assign busy      = (state_q == EMIT);
    assign out_valid = busy;
    assign out_idx   = idx;
    assign out_last  = busy & last;
    assign out_bin   = busy ? peak_q[idx][24:16] : 9'd0;
    assign out_mag   = busy ? peak_q[idx][15:0] : 16'd0;
    assign out_frame = frame_q;
    assign drop      = drop_q;

endmodule
